ntt_mem_arbiter: RTL and testbench
==================================

// Module: ntt_mem_arbiter
// PURPOSE
//  Shares one 64-bit host/DDR memory port among NUM_CORES ntt_engine DMA ports (arb_* interfaces).
//  Per-beat round-robin grant; read responses return in order and are routed back to the issuing core
//  through a tag FIFO. Sits between the engine array and the memory controller.
// PARAMETERS
//  NUM_CORES   4    number of engine requesters (2..8)
//  ADDR_W      48   byte address width
//  DATA_W      64   data beat width
//  TAG_DEPTH   16   max outstanding reads (power of 2); tag FIFO depth
// PORTS
//  clk          in   1                  clock; all logic on posedge
//  rst          in   1                  synchronous reset, active-high
//  core_req     in   NUM_CORES          per-core request (held until granted)
//  core_we      in   NUM_CORES          per-core write enable (1=write, 0=read)
//  core_addr    in   NUM_CORES*ADDR_W   per-core address, core i at [i*ADDR_W +: ADDR_W]
//  core_wdata   in   NUM_CORES*DATA_W   per-core write data
//  core_gnt     out  NUM_CORES          combinational; one-hot or zero; beat accepted this cycle
//  core_valid   out  NUM_CORES          registered; one-hot read-data strobe
//  core_rdata   out  DATA_W             registered; read data, shared by all cores
//  mem_req      out  1                  combinational; a beat is presented to memory
//  mem_we       out  1                  combinational; we of selected core
//  mem_addr     out  ADDR_W             combinational; addr of selected core
//  mem_wdata    out  DATA_W             combinational; wdata of selected core
//  mem_gnt      in   1                  memory accepts the presented beat this cycle
//  mem_rvalid   in   1                  in-order read response valid
//  mem_rdata    in   DATA_W             read response data
//  outstanding  out  $clog2(TAG_DEPTH)+1  registered; reads issued, not yet returned
//  err_orphan   out  1                  sticky; mem_rvalid seen with empty tag FIFO
// BEHAVIOUR
//  - Eligible[i] = core_req[i] & (core_we[i] | !fifo_full). Full blocks reads only; writes pass.
//  - Selection: first eligible index at or after rr_ptr, wrapping modulo NUM_CORES. mem_* mirrors it.
//  - mem_req = |eligible. Idle mem_we/addr/wdata = 0.
//  - core_gnt[sel] = mem_req & mem_gnt, same cycle. All other gnt bits = 0.
//  - On grant: rr_ptr <= (sel+1) mod NUM_CORES. No grant: rr_ptr holds. Arbitration is per beat (no lock).
//  - Granted read: push sel into tag FIFO. Writes push nothing; no write acks.
//  - mem_rvalid with FIFO non-empty: pop tag t. Next cycle core_valid = one-hot(t), core_rdata = mem_rdata.
//    Read-return latency = 1 cycle. core_valid is 0 in every cycle without a pop on the previous edge.
//    core_rdata holds its last value.
//  - mem_rvalid with FIFO empty: no pop, no core_valid, err_orphan <= 1 (cleared only by rst).
//  - Same-cycle push and pop: both occur; count unchanged. Allowed when full; the full check uses the
//    pre-pop count, so a read is still blocked that cycle.
//  - outstanding = FIFO count. Range 0..TAG_DEPTH. Pointers wrap modulo TAG_DEPTH.
//  - Memory returns reads in issue order. The block does no reordering.
//  - Reset: rr_ptr=0, FIFO emptied (rd/wr ptr=0, count=0), core_valid=0, core_rdata=0, outstanding=0,
//    err_orphan=0. Comb outputs drop to 0 when core_req=0.
//  - Reset mid-operation discards all in-flight tags. Late responses then raise err_orphan; the system
//    must also reset memory.
// TESTING
//  1. Core0 only, 3 reads @0x1000/0x1008/0x1010, mem_gnt=1, rvalid 2 cycles later
//     -> 3 gnts; core_valid[0] 3x, 1 cycle after each rvalid; data matches; outstanding 0 at end.
//  2. All 4 cores hold req, mem_gnt=1 -> grant order 0,1,2,3,0,1; core_gnt never multi-hot.
//  3. Cores 1 and 3 alternate reads, memory returns D1a,D3a,D1b -> core_valid 1,3,1 with matching data.
//  4. TAG_DEPTH=16 reads issued, no rvalid -> outstanding=16. Further core0 reads get no gnt; core2 write
//     still granted. Then rvalid + read req in the same cycle -> pop only; push accepted the next cycle.
//  5. mem_rvalid with outstanding=0 -> err_orphan=1 and stays 1; no core_valid.
//  6. rst asserted with 5 outstanding -> next cycle outstanding=0, rr_ptr=0, core_valid=0; next grant to
//     the lowest requesting index.

Source files
------------

// File: rtl/ntt_mem_arbiter.sv
// ntt_mem_arbiter: shares one memory port among NUM_CORES engine DMA ports.
// Per-beat round-robin grant; in-order read returns routed back via a tag FIFO.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   core_req/we         per-core request and write enable
//   core_addr/wdata     per-core packed address and write data
//   core_gnt            comb one-hot grant (beat accepted by memory this cycle)
//   core_valid/rdata    registered read-return strobe and shared read data
//   mem_req/we/addr/wdata  comb beat presented to memory
//   mem_gnt             memory accepts the presented beat
//   mem_rvalid/rdata    in-order read response from memory
//   outstanding         registered count of reads issued, not yet returned
//   err_orphan          sticky: response arrived with no outstanding read
module ntt_mem_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 48,
    parameter int DATA_W    = 64,
    parameter int TAG_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CORES-1:0]        core_req,
    input  logic [NUM_CORES-1:0]        core_we,
    input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
    input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
    output logic [NUM_CORES-1:0]        core_gnt,
    output logic [NUM_CORES-1:0]        core_valid,
    output logic [DATA_W-1:0]           core_rdata,
    output logic                        mem_req,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic                        mem_gnt,
    input  logic                        mem_rvalid,
    input  logic [DATA_W-1:0]           mem_rdata,
    output logic [$clog2(TAG_DEPTH):0]  outstanding,
    output logic                        err_orphan
);

    localparam int IDX_W = $clog2(NUM_CORES);
    localparam int PTR_W = $clog2(TAG_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [IDX_W-1:0]     tag_mem_q [TAG_DEPTH];
    logic [IDX_W-1:0]     tag_mem_d [TAG_DEPTH];
    logic [NUM_CORES-1:0] core_valid_q, core_valid_d;
    logic [DATA_W-1:0]    core_rdata_q, core_rdata_d;
    logic                 err_orphan_q, err_orphan_d;

    logic [ADDR_W-1:0]    addr_arr  [NUM_CORES];
    logic [DATA_W-1:0]    wdata_arr [NUM_CORES];

    logic [NUM_CORES-1:0] eligible;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [IDX_W-1:0]     sel;
    logic                 found;
    logic [IDX_W:0]       cand_sum;
    logic [IDX_W-1:0]     cand;
    logic                 grant;
    logic                 push;
    logic                 pop;

    for (genvar i = 0; i < NUM_CORES; i++) begin : g_unpack
        assign addr_arr[i]  = core_addr[i*ADDR_W +: ADDR_W];
        assign wdata_arr[i] = core_wdata[i*DATA_W +: DATA_W];
    end

    // Full check uses the pre-pop count: a same-cycle pop never frees a slot
    // for a read in that cycle. Writes never occupy tags, so they bypass it.
    assign fifo_full  = (count_q == CNT_W'(TAG_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign eligible   = core_req & (core_we | {NUM_CORES{~fifo_full}});

    // First eligible index at or after rr_ptr, wrapping modulo NUM_CORES.
    always_comb begin
        sel      = '0;
        found    = 1'b0;
        cand_sum = '0;
        cand     = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            cand_sum = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
            if (cand_sum >= (IDX_W+1)'(NUM_CORES)) begin
                cand_sum = cand_sum - (IDX_W+1)'(NUM_CORES);
            end
            cand = cand_sum[IDX_W-1:0];
            if (!found && eligible[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
    end

    assign mem_req = found;
    assign grant   = found & mem_gnt;
    assign push    = grant & ~core_we[sel];
    assign pop     = mem_rvalid & ~fifo_empty;

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        core_gnt  = '0;
        if (found) begin
            mem_we    = core_we[sel];
            mem_addr  = addr_arr[sel];
            mem_wdata = wdata_arr[sel];
        end
        if (grant) begin
            core_gnt = NUM_CORES'(1) << sel;
        end
    end

    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        tag_mem_d    = tag_mem_q;
        core_valid_d = '0;
        core_rdata_d = core_rdata_q;
        err_orphan_d = err_orphan_q;

        if (grant) begin
            if (sel == IDX_W'(NUM_CORES - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = sel + IDX_W'(1);
            end
        end

        if (push) begin
            tag_mem_d[wr_ptr_q] = sel;
            wr_ptr_d            = wr_ptr_q + PTR_W'(1);
        end

        if (pop) begin
            core_valid_d = NUM_CORES'(1) << tag_mem_q[rd_ptr_q];
            core_rdata_d = mem_rdata;
            rd_ptr_d     = rd_ptr_q + PTR_W'(1);
        end

        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end

        if (mem_rvalid && fifo_empty) begin
            err_orphan_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            core_valid_q <= '0;
            core_rdata_q <= '0;
            err_orphan_q <= 1'b0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            core_valid_q <= core_valid_d;
            core_rdata_q <= core_rdata_d;
            err_orphan_q <= err_orphan_d;
        end
    end

    // Tag storage needs no reset: entries are only read below count_q.
    always_ff @(posedge clk) begin
        tag_mem_q <= tag_mem_d;
    end

    assign core_valid  = core_valid_q;
    assign core_rdata  = core_rdata_q;
    assign outstanding = count_q;
    assign err_orphan  = err_orphan_q;

endmodule

// File: tb/tb_ntt_mem_arbiter.sv
// tb_ntt_mem_arbiter: vector table, directed corner sequences and random
// traffic checked against a queue-based reference model.
module tb_ntt_mem_arbiter;

    localparam int NC = 4;
    localparam int AW = 48;
    localparam int DW = 64;
    localparam int TD = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [NC-1:0]     req;
    logic [NC-1:0]     we;
    logic [NC*AW-1:0]  addr;
    logic [NC*DW-1:0]  wdata;
    logic [NC-1:0]     core_gnt;
    logic [NC-1:0]     core_valid;
    logic [DW-1:0]     core_rdata;
    logic              mem_req;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic              mgnt;
    logic              rvalid;
    logic [DW-1:0]     rdata;
    logic [4:0]        outstanding;
    logic              err_orphan;

    ntt_mem_arbiter #(
        .NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW), .TAG_DEPTH(TD)
    ) dut (
        .clk(clk), .rst(rst),
        .core_req(req), .core_we(we),
        .core_addr(addr), .core_wdata(wdata),
        .core_gnt(core_gnt), .core_valid(core_valid),
        .core_rdata(core_rdata),
        .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mgnt), .mem_rvalid(rvalid), .mem_rdata(rdata),
        .outstanding(outstanding), .err_orphan(err_orphan)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model: rotation pointer, tag queue, expected registered outputs.
    int            m_rr;
    int            m_q[$];
    bit            m_err;
    logic [NC-1:0] m_valid;
    logic [DW-1:0] m_rdata;

    logic [NC-1:0] last_gnt;
    logic          last_mreq;
    logic [NC-1:0] last_valid;
    logic [DW-1:0] last_rdata;

    typedef struct {
        logic [NC-1:0] req;
        logic [NC-1:0] we;
        logic          mgnt;
        logic          exp_req;
        logic [NC-1:0] exp_gnt;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h",
                     nm, cyc, act, exp);
        end
    endtask

    // Called just after a negedge with inputs already driven.
    task automatic cycle();
        int sel;
        int idx;
        int t;
        logic [NC-1:0] eg;
        bit pop;
        #1;
        sel = -1;
        for (int k = 0; k < NC; k++) begin
            idx = (m_rr + k) % NC;
            if (sel < 0 && req[idx] && (we[idx] || m_q.size() < TD))
                sel = idx;
        end
        eg = (sel >= 0 && mgnt) ? NC'(1 << sel) : '0;
        chk("core_gnt", 64'(core_gnt), 64'(eg));
        chk("mem_req", 64'(mem_req), 64'(sel >= 0));
        chk("mem_we", 64'(mem_we), (sel >= 0) ? 64'(we[sel]) : 64'd0);
        chk("mem_addr", 64'(mem_addr),
            (sel >= 0) ? 64'(addr[sel*AW +: AW]) : 64'd0);
        chk("mem_wdata", mem_wdata,
            (sel >= 0) ? wdata[sel*DW +: DW] : 64'd0);
        last_gnt  = core_gnt;
        last_mreq = mem_req;
        @(posedge clk);
        pop = rvalid && (m_q.size() > 0);
        if (rvalid && m_q.size() == 0) m_err = 1'b1;
        if (pop) begin
            t       = m_q.pop_front();
            m_valid = NC'(1 << t);
            m_rdata = rdata;
        end else begin
            m_valid = '0;
        end
        if (eg != 0) begin
            m_rr = (sel + 1) % NC;
            if (!we[sel]) m_q.push_back(sel);
        end
        #1;
        chk("core_valid", 64'(core_valid), 64'(m_valid));
        chk("core_rdata", core_rdata, m_rdata);
        chk("outstanding", 64'(outstanding), 64'(m_q.size()));
        chk("err_orphan", 64'(err_orphan), 64'(m_err));
        last_valid = core_valid;
        last_rdata = core_rdata;
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        req    = '0;
        we     = '0;
        mgnt   = 1'b0;
        rvalid = 1'b0;
        rdata  = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        @(posedge clk);
        #1;
        chk("rst_outstanding", 64'(outstanding), 64'd0);
        chk("rst_valid", 64'(core_valid), 64'd0);
        chk("rst_rdata", core_rdata, 64'd0);
        chk("rst_err", 64'(err_orphan), 64'd0);
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        m_rr    = 0;
        m_q.delete();
        m_err   = 1'b0;
        m_valid = '0;
        m_rdata = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int gcnt;
        int vcnt;
        logic [NC-1:0] obs_v [3];
        logic [DW-1:0] obs_d [3];

        // Rotation table, all writes so the tag FIFO is never involved.
        vecs[0]  = vec_t'{4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0001};
        vecs[1]  = vec_t'{4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0010};
        vecs[2]  = vec_t'{4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0100};
        vecs[3]  = vec_t'{4'b1111, 4'b1111, 1'b1, 1'b1, 4'b1000};
        vecs[4]  = vec_t'{4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0001};
        vecs[5]  = vec_t'{4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0010};
        vecs[6]  = vec_t'{4'b0000, 4'b1111, 1'b1, 1'b0, 4'b0000};
        vecs[7]  = vec_t'{4'b0001, 4'b1111, 1'b1, 1'b1, 4'b0001};
        vecs[8]  = vec_t'{4'b1001, 4'b1111, 1'b0, 1'b1, 4'b0000};
        vecs[9]  = vec_t'{4'b1001, 4'b1111, 1'b1, 1'b1, 4'b1000};
        vecs[10] = vec_t'{4'b1010, 4'b1111, 1'b1, 1'b1, 4'b0010};
        vecs[11] = vec_t'{4'b0011, 4'b1111, 1'b1, 1'b1, 4'b0001};

        for (int i = 0; i < NC; i++) begin
            addr[i*AW +: AW]  = AW'(48'hA000 + i * 'h100);
            wdata[i*DW +: DW] = DW'(64'h5500_0000 + i);
        end

        do_reset();

        // Table: round-robin order and per-beat rotation.
        for (int i = 0; i < 12; i++) begin
            req  = vecs[i].req;
            we   = vecs[i].we;
            mgnt = vecs[i].mgnt;
            cycle();
            chk("vec_gnt", 64'(last_gnt), 64'(vecs[i].exp_gnt));
            chk("vec_mem_req", 64'(last_mreq), 64'(vecs[i].exp_req));
        end

        // Core0 three reads, responses two cycles after each issue.
        do_reset();
        gcnt = 0;
        vcnt = 0;
        for (int c = 0; c < 8; c++) begin
            req    = (c < 3) ? 4'b0001 : 4'b0000;
            we     = '0;
            addr[0 +: AW] = AW'(48'h1000 + 8 * c);
            mgnt   = 1'b1;
            rvalid = (c >= 2 && c < 5);
            rdata  = 64'hD0D0_0000 + 64'(c);
            cycle();
            gcnt += int'(last_gnt[0]);
            vcnt += int'(last_valid[0]);
        end
        chk("t1_gnt_count", 64'(gcnt), 64'd3);
        chk("t1_valid_count", 64'(vcnt), 64'd3);
        chk("t1_outstanding", 64'(outstanding), 64'd0);

        // Cores 1 and 3 interleaved reads, in-order routing back.
        do_reset();
        mgnt = 1'b1;
        we   = '0;
        req = 4'b0010; cycle();
        req = 4'b1000; cycle();
        req = 4'b0010; cycle();
        req = '0;
        for (int c = 0; c < 3; c++) begin
            rvalid = 1'b1;
            rdata  = 64'hDA7A_0000 + 64'(c);
            cycle();
            obs_v[c] = last_valid;
            obs_d[c] = last_rdata;
        end
        rvalid = 1'b0;
        chk("t3_valid0", 64'(obs_v[0]), 64'h2);
        chk("t3_valid1", 64'(obs_v[1]), 64'h8);
        chk("t3_valid2", 64'(obs_v[2]), 64'h2);
        chk("t3_data0", obs_d[0], 64'hDA7A_0000);
        chk("t3_data1", obs_d[1], 64'hDA7A_0001);
        chk("t3_data2", obs_d[2], 64'hDA7A_0002);

        // Full FIFO: reads blocked, writes pass, pop does not free same cycle.
        do_reset();
        mgnt = 1'b1;
        for (int c = 0; c < TD; c++) begin
            req = 4'b0001; we = '0; cycle();
        end
        chk("t4_full", 64'(outstanding), 64'd16);
        req = 4'b0001; cycle();
        chk("t4_read_blocked", 64'(last_gnt), 64'd0);
        chk("t4_no_mem_req", 64'(last_mreq), 64'd0);
        req = 4'b0101; we = 4'b0100; cycle();
        chk("t4_write_passes", 64'(last_gnt), 64'h4);
        req = 4'b0001; we = '0; rvalid = 1'b1; rdata = 64'hF00D;
        cycle();
        chk("t4_pop_no_push", 64'(last_gnt), 64'd0);
        chk("t4_after_pop", 64'(outstanding), 64'd15);
        rvalid = 1'b0;
        cycle();
        chk("t4_push_next", 64'(last_gnt), 64'h1);
        chk("t4_refull", 64'(outstanding), 64'd16);
        req = '0;
        for (int c = 0; c < TD; c++) begin
            rvalid = 1'b1; rdata = 64'(c); cycle();
        end
        rvalid = 1'b0;
        chk("t4_drained", 64'(outstanding), 64'd0);

        // Orphan response with nothing outstanding.
        do_reset();
        rvalid = 1'b1; cycle();
        chk("t5_err_set", 64'(err_orphan), 64'd1);
        chk("t5_no_valid", 64'(last_valid), 64'd0);
        rvalid = 1'b0;
        for (int c = 0; c < 3; c++) cycle();
        chk("t5_err_sticky", 64'(err_orphan), 64'd1);

        // Reset mid-operation with five reads in flight.
        do_reset();
        mgnt = 1'b1;
        for (int c = 0; c < 5; c++) begin
            req = 4'b0100; we = '0; cycle();
        end
        chk("t6_pre", 64'(outstanding), 64'd5);
        do_reset();
        mgnt = 1'b1;
        req = 4'b1010; we = '0; cycle();
        chk("t6_lowest_after_rst", 64'(last_gnt), 64'h2);
        req = '0; rvalid = 1'b1; rdata = 64'h1234; cycle();
        rvalid = 1'b0;
        cycle();
        chk("t6_valid_after_rst", 64'(last_valid), 64'd0);

        // Random traffic against the model; responses only when owed.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            req  = NC'($urandom);
            we   = NC'($urandom);
            mgnt = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NC; i++) begin
                addr[i*AW +: AW]  = AW'({$urandom, $urandom});
                wdata[i*DW +: DW] = {$urandom, $urandom};
            end
            rvalid = (m_q.size() > 0) && ($urandom_range(0, 2) == 0);
            rdata  = {$urandom, $urandom};
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
